sr_ff_bank: RTL and testbench
=============================

// Module: sr_ff_bank
// PURPOSE
//  Parametrised bank of CHANNELS independent set/reset flags with a selectable
//  collision policy, per-channel auto-clear timeout, edge-event pulses and sticky
//  collision capture. Replaces ad-hoc arrays of single sr flip-flops for the
//  running/busy/valid flags of the conv and FC engines.
// PARAMETERS
//  CHANNELS       8        number of independent flag channels (>=1)
//  POLICY         SR_SET   sr_ff_pkg::sr_policy_e; SR_SET | SR_RESET | SR_TOGGLE
//  TIMEOUT_CYCLES 0        auto-clear after N cycles set; 0 = disabled (2..2^16)
//  INIT           '0       [CHANNELS-1:0] flag values loaded by reset
// PORTS
//  clk_i         in   1         single clock, all state on posedge
//  rst_i         in   1         synchronous, active-high reset
//  set_i         in   CHANNELS  per-channel set request
//  srst_i        in   CHANNELS  per-channel synchronous clear request
//  data_o        out  CHANNELS  registered flag state
//  rise_o        out  CHANNELS  1-cycle pulse, flag went 0->1 this edge
//  fall_o        out  CHANNELS  1-cycle pulse, flag went 1->0 (any cause)
//  timeout_o     out  CHANNELS  1-cycle pulse, flag cleared by timeout
//  collision_o   out  CHANNELS  sticky: set_i&srst_i seen on channel
//  coll_clr_i    in   1         clears all collision_o bits
//  assert_on_i   in   1         sim only; enables collision $error, no functional effect
// BEHAVIOUR
//  - Reset: rst_i high at posedge -> data_o=INIT, rise_o/fall_o/timeout_o=0,
//    collision_o=0, counters=0. Overrides all other inputs; valid mid-timeout.
//  - Latency: data_o reflects set_i/srst_i one edge after they are sampled.
//  - Per-channel next state, precedence high->low:
//    1 set_i&srst_i: SR_SET->1, SR_RESET->0, SR_TOGGLE->~data_o
//    2 set_i->1   3 srst_i->0   4 timeout expiry->0   5 hold
//  - Timeout (TIMEOUT_CYCLES=N>0): counter width $clog2(N); cleared whenever
//    next state is 1 due to set_i (re-set while set restarts count) or flag
//    is 0; increments each cycle flag is 1 with no set_i. When flag is 1, count==N-1
//    and neither set_i nor srst_i -> flag clears, timeout_o pulses with the
//    clearing edge. Flag therefore stays high exactly N cycles after last set.
//    srst_i on the expiry cycle -> clears, timeout_o stays 0.
//  - rise_o/fall_o registered alongside data_o: rise_o = next&~cur,
//    fall_o = ~next&cur. Never both high. Toggle collision on a 1 gives fall.
//  - collision_o[c] sets on any cycle set_i[c]&srst_i[c]; coll_clr_i clears all,
//    but a collision in the same cycle as coll_clr_i leaves that bit set.
//  - Collisions are legal hardware behaviour (policy-defined); assertion only
//    reports when assert_on_i=1, message names channel index.
//  - TIMEOUT_CYCLES=1 illegal: elaboration $error. CHANNELS=1 must elaborate.
// STRUCTURE
//  - sr_ff_pkg: typedef enum logic [1:0] {SR_SET, SR_RESET, SR_TOGGLE}
//    sr_policy_e; function next_flag(set,srst,cur,policy) shared with sr_ff users.
//  - Sub-module sr_flag_channel: one flag, its counter, edge/timeout pulses;
//    generate-loop CHANNELS instances. Collision sticky regs and coll_clr_i
//    handling stay in top level.
// TESTING
//  1 Reset: INIT=8'hA5, rst_i 1 cycle -> data_o=8'hA5, all pulses/collision_o 0;
//    rst_i mid-timeout ch0 -> ch0=INIT[0], no timeout_o pulse.
//  2 Policies: set_i=srst_i=1 on ch2, data_o[2]=1 -> SR_SET stays 1,
//    SR_RESET ->0 + fall_o[2], SR_TOGGLE ->0 then ->1 with rise_o on repeat.
//  3 Timeout N=4: set_i[1] 1 cycle at T -> data_o[1]=1 T+1..T+4, 0 at T+5,
//    timeout_o[1] pulse at T+5; re-set at T+3 -> stays high to T+7.
//  4 Expiry race N=4: srst_i[1] on expiry cycle -> fall_o[1]=1, timeout_o[1]=0;
//    set_i[1] on expiry cycle -> remains 1, counter restarts.
//  5 Collision sticky: collide ch5, then coll_clr_i -> bit5 clears; collide ch5
//    same cycle as coll_clr_i -> collision_o[5] stays 1; $error only if assert_on_i.
//  6 Independence: random set/srst across 8 channels vs package-function model,
//    10k cycles, data_o/rise_o/fall_o match every cycle.

Source files
------------

// File: rtl/sr_ff_pkg.sv
// rtl/sr_ff_pkg.sv - shared types and next-state function for set/reset flags
package sr_ff_pkg;

    typedef enum logic [1:0] {
        SR_SET    = 2'd0,
        SR_RESET  = 2'd1,
        SR_TOGGLE = 2'd2
    } sr_policy_e;

    localparam int unsigned SR_TIMEOUT_MAX = 65536;

    // Resolves set/clear requests for one flag; collision handling follows the policy.
    function automatic logic next_flag(
        input logic       set,
        input logic       srst,
        input logic       cur,
        input sr_policy_e policy
    );
        logic nxt;
        nxt = cur;
        if (set && srst) begin
            case (policy)
                SR_SET:    nxt = 1'b1;
                SR_RESET:  nxt = 1'b0;
                SR_TOGGLE: nxt = ~cur;
                default:   nxt = cur;
            endcase
        end else if (set) begin
            nxt = 1'b1;
        end else if (srst) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sr_flag_channel.sv
// rtl/sr_flag_channel.sv - one set/reset flag with auto-clear timer and edge pulses
module sr_flag_channel
    import sr_ff_pkg::*;
#(
    parameter sr_policy_e  POLICY         = SR_SET,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic        INIT           = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic srst_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o,
    output logic timeout_o
);

    logic r_data;
    logic r_rise;
    logic r_fall;
    logic r_timeout;
    logic w_next_req;
    logic w_expire;
    logic w_next;

    assign w_next_req = next_flag(set_i, srst_i, r_data, POLICY);
    // Expiry is the lowest-priority cause, so it only acts when no request is present.
    assign w_next     = w_expire ? 1'b0 : w_next_req;

    generate
        if (TIMEOUT_CYCLES > 1) begin : g_timer
            localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_cnt;

            assign w_expire = r_data && !set_i && !srst_i && (r_cnt == LAST);

            // Counts cycles held high since the last set; any set or a low flag restarts it.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (set_i || !w_next) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    // Flag state and its edge/timeout pulses, all registered on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= INIT;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_data    <= w_next;
            r_rise    <= w_next & ~r_data;
            r_fall    <= ~w_next & r_data;
            r_timeout <= w_expire;
        end
    end

    assign data_o    = r_data;
    assign rise_o    = r_rise;
    assign fall_o    = r_fall;
    assign timeout_o = r_timeout;

endmodule

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - bank of independent set/reset flags with sticky collision capture
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int unsigned          CHANNELS       = 8,
    parameter sr_policy_e           POLICY         = SR_SET,
    parameter int unsigned          TIMEOUT_CYCLES = 0,
    parameter logic [CHANNELS-1:0]  INIT           = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] set_i,
    input  logic [CHANNELS-1:0] srst_i,
    output logic [CHANNELS-1:0] data_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] timeout_o,
    output logic [CHANNELS-1:0] collision_o,
    input  logic                coll_clr_i,
    input  logic                assert_on_i
);

    logic [CHANNELS-1:0] r_coll;
    logic [CHANNELS-1:0] w_coll_now;

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("sr_ff_bank: CHANNELS must be at least 1");
        end
        if (TIMEOUT_CYCLES == 1) begin : g_bad_timeout_one
            $error("sr_ff_bank: TIMEOUT_CYCLES=1 is not supported, use 0 or 2..65536");
        end
        if (TIMEOUT_CYCLES > SR_TIMEOUT_MAX) begin : g_bad_timeout_max
            $error("sr_ff_bank: TIMEOUT_CYCLES exceeds 65536");
        end
    endgenerate

    assign w_coll_now = set_i & srst_i;

    // Sticky collision capture; a collision coinciding with the clear wins for its bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_coll <= '0;
        end else begin
            r_coll <= (coll_clr_i ? '0 : r_coll) | w_coll_now;
        end
    end

    assign collision_o = r_coll;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            sr_flag_channel #(
                .POLICY         (POLICY),
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .INIT           (INIT[c])
            ) u_chan (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .set_i     (set_i[c]),
                .srst_i    (srst_i[c]),
                .data_o    (data_o[c]),
                .rise_o    (rise_o[c]),
                .fall_o    (fall_o[c]),
                .timeout_o (timeout_o[c])
            );

`ifndef SYNTHESIS
            // Simulation report of a collision; the hardware result is still policy-defined.
            always @(posedge clk_i) begin
                if (!rst_i && assert_on_i) begin
                    assert (!w_coll_now[c])
                    else $error("sr_ff_bank: set/srst collision on channel %0d", c);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb/tb_sr_ff_bank.sv - table-driven and scoreboard bench for sr_ff_bank
module tb_sr_ff_bank;
    import sr_ff_pkg::*;

    localparam logic [7:0] INIT_V = 8'hA5;

    typedef struct packed {
        logic [3:0][7:0] dat;
        logic [3:0][7:0] rise;
        logic [3:0][7:0] fall;
        logic [3:0][7:0] tout;
        logic [7:0]      coll;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] set;
        logic [7:0] srst;
        logic       clr;
        logic [7:0] e_set;
        logic [7:0] e_rst;
        logic [7:0] e_tog;
        logic [7:0] e_coll;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       aon;
    logic [7:0] set_v;
    logic [7:0] srst_v;

    logic [7:0] o_dat  [3];
    logic [7:0] o_rise [3];
    logic [7:0] o_fall [3];
    logic [7:0] o_to   [3];
    logic [7:0] o_coll [3];
    logic       one_dat, one_rise, one_fall, one_to, one_coll;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_flag [4];
    int          m_cnt  [4][8];
    logic [7:0]  m_coll;
    sr_policy_e  pol    [4];
    int          tmo    [4];
    exp_t        sb[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    sr_ff_bank #(.CHANNELS(8), .POLICY(SR_SET), .TIMEOUT_CYCLES(4), .INIT(INIT_V)) u_set (
        .clk_i(clk), .rst_i(rst), .set_i(set_v), .srst_i(srst_v),
        .data_o(o_dat[0]), .rise_o(o_rise[0]), .fall_o(o_fall[0]), .timeout_o(o_to[0]),
        .collision_o(o_coll[0]), .coll_clr_i(clr), .assert_on_i(aon));

    sr_ff_bank #(.CHANNELS(8), .POLICY(SR_RESET), .TIMEOUT_CYCLES(4), .INIT(INIT_V)) u_rst (
        .clk_i(clk), .rst_i(rst), .set_i(set_v), .srst_i(srst_v),
        .data_o(o_dat[1]), .rise_o(o_rise[1]), .fall_o(o_fall[1]), .timeout_o(o_to[1]),
        .collision_o(o_coll[1]), .coll_clr_i(clr), .assert_on_i(aon));

    sr_ff_bank #(.CHANNELS(8), .POLICY(SR_TOGGLE), .TIMEOUT_CYCLES(0), .INIT(INIT_V)) u_tog (
        .clk_i(clk), .rst_i(rst), .set_i(set_v), .srst_i(srst_v),
        .data_o(o_dat[2]), .rise_o(o_rise[2]), .fall_o(o_fall[2]), .timeout_o(o_to[2]),
        .collision_o(o_coll[2]), .coll_clr_i(clr), .assert_on_i(aon));

    sr_ff_bank #(.CHANNELS(1), .POLICY(SR_SET), .TIMEOUT_CYCLES(2), .INIT(1'b1)) u_one (
        .clk_i(clk), .rst_i(rst), .set_i(set_v[0]), .srst_i(srst_v[0]),
        .data_o(one_dat), .rise_o(one_rise), .fall_o(one_fall), .timeout_o(one_to),
        .collision_o(one_coll), .coll_clr_i(clr), .assert_on_i(aon));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic r, input logic [7:0] s, input logic [7:0] k, input logic c);
        exp_t e;
        exp_t g;
        e = '0;
        rst = r; set_v = s; srst_v = k; clr = c;
        for (int d = 0; d < 4; d++) begin
            for (int ch = 0; ch < 8; ch++) begin
                logic f, nf, tp;
                f  = m_flag[d][ch];
                tp = 1'b0;
                if (r) begin
                    nf = INIT_V[ch];
                    m_cnt[d][ch] = 0;
                end else begin
                    if (s[ch] && k[ch])
                        nf = (pol[d] == SR_SET) ? 1'b1 : (pol[d] == SR_RESET) ? 1'b0 : ~f;
                    else if (s[ch])
                        nf = 1'b1;
                    else if (k[ch])
                        nf = 1'b0;
                    else if (tmo[d] > 0 && f && m_cnt[d][ch] == tmo[d] - 1) begin
                        nf = 1'b0;
                        tp = 1'b1;
                    end else
                        nf = f;
                    if (s[ch] && nf)
                        m_cnt[d][ch] = 0;
                    else if (f && nf)
                        m_cnt[d][ch] = m_cnt[d][ch] + 1;
                    else
                        m_cnt[d][ch] = 0;
                    e.rise[d][ch] = nf & ~f;
                    e.fall[d][ch] = ~nf & f;
                    e.tout[d][ch] = tp;
                end
                e.dat[d][ch] = nf;
                m_flag[d][ch] = nf;
            end
        end
        m_coll = r ? 8'h00 : ((c ? 8'h00 : m_coll) | (s & k));
        e.coll = m_coll;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            g = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("data[%0d]", d), o_dat[d], g.dat[d]);
                chk($sformatf("rise[%0d]", d), o_rise[d], g.rise[d]);
                chk($sformatf("fall[%0d]", d), o_fall[d], g.fall[d]);
                chk($sformatf("timeout[%0d]", d), o_to[d], g.tout[d]);
                chk($sformatf("collision[%0d]", d), o_coll[d], g.coll);
            end
            chk("one_ch", {3'b000, one_dat, one_rise, one_fall, one_to, one_coll},
                {3'b000, g.dat[3][0], g.rise[3][0], g.fall[3][0], g.tout[3][0], g.coll[0]});
        end
    endtask

    task automatic add(input logic r, input logic [7:0] s, input logic [7:0] k, input logic c,
                       input logic [7:0] es, input logic [7:0] er, input logic [7:0] et,
                       input logic [7:0] ec);
        vec_t v;
        v = '{rst: r, set: s, srst: k, clr: c, e_set: es, e_rst: er, e_tog: et, e_coll: ec};
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic [7:0] es, input logic [7:0] er, input logic [7:0] et);
        for (int i = 0; i < n; i++) add(1'b0, 8'h00, 8'h00, 1'b0, es, er, et, 8'h20);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; aon = 1'b0; set_v = '0; srst_v = '0;
        pol[0] = SR_SET; pol[1] = SR_RESET; pol[2] = SR_TOGGLE; pol[3] = SR_SET;
        tmo[0] = 4; tmo[1] = 4; tmo[2] = 0; tmo[3] = 2;
        for (int d = 0; d < 4; d++) begin
            m_flag[d] = INIT_V;
            for (int ch = 0; ch < 8; ch++) m_cnt[d][ch] = 0;
        end
        m_coll = '0;

        //    rst  set    srst   clr   set    rst    tog    coll
        add(1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        add(1'b0, 8'h04, 8'h04, 1'b0, 8'hA5, 8'hA1, 8'hA1, 8'h04);
        add(1'b0, 8'h04, 8'h04, 1'b0, 8'hA5, 8'hA1, 8'hA5, 8'h04);
        add(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 8'hA1, 8'hA5, 8'h00);
        add(1'b0, 8'h20, 8'h20, 1'b1, 8'h24, 8'h00, 8'h85, 8'h20);
        idle(1, 8'h24, 8'h00, 8'h85);
        add(1'b0, 8'h02, 8'h00, 1'b0, 8'h22, 8'h02, 8'h87, 8'h20);
        idle(1, 8'h22, 8'h02, 8'h87);
        idle(1, 8'h02, 8'h02, 8'h87);
        add(1'b0, 8'h02, 8'h00, 1'b0, 8'h02, 8'h02, 8'h87, 8'h20);
        idle(3, 8'h02, 8'h02, 8'h87);
        idle(1, 8'h00, 8'h00, 8'h87);
        add(1'b0, 8'h02, 8'h00, 1'b0, 8'h02, 8'h02, 8'h87, 8'h20);
        idle(3, 8'h02, 8'h02, 8'h87);
        add(1'b0, 8'h00, 8'h02, 1'b0, 8'h00, 8'h00, 8'h85, 8'h20);
        add(1'b0, 8'h02, 8'h00, 1'b0, 8'h02, 8'h02, 8'h87, 8'h20);
        idle(3, 8'h02, 8'h02, 8'h87);
        add(1'b0, 8'h02, 8'h00, 1'b0, 8'h02, 8'h02, 8'h87, 8'h20);
        idle(3, 8'h02, 8'h02, 8'h87);
        idle(1, 8'h00, 8'h00, 8'h87);
        add(1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 8'h01, 8'h87, 8'h20);
        idle(1, 8'h01, 8'h01, 8'h87);
        add(1'b1, 8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'h00);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].set, tbl[i].srst, tbl[i].clr);
            chk($sformatf("vec%0d set_data", i), o_dat[0], tbl[i].e_set);
            chk($sformatf("vec%0d rst_data", i), o_dat[1], tbl[i].e_rst);
            chk($sformatf("vec%0d tog_data", i), o_dat[2], tbl[i].e_tog);
            chk($sformatf("vec%0d collision", i), o_coll[0], tbl[i].e_coll);
        end

        for (int i = 0; i < 10000; i++) begin
            logic [7:0] s, k;
            s = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
            k = 8'($urandom()) & 8'($urandom()) & 8'($urandom()) & 8'($urandom());
            step($urandom_range(0, 499) == 0, s, k, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
